// File: rtl/mult_seq_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply sequencer and the writeback mux.
// The writeback mux decodes the same WB_SEL_* values that the sequencer drives.
package mult_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_MUL = 2'b10;

    // The multiply source wins only while the product is presented; 2'b11 is never produced.
    function automatic logic [1:0] wb_sel_for(input logic mul_done, input logic mem_to_reg);
        if (mul_done)
            return WB_SEL_MUL;
        return mem_to_reg ? WB_SEL_MEM : WB_SEL_ALU;
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// EX-stage multiply handshake: the pipeline (master) issues operands and
// control, the sequencer (slave) returns stall, product and writeback select.
interface mult_seq_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              mult_req;
    logic              flush;
    logic              mem_to_reg;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              stall;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [1:0]        wb_sel;

    modport master (
        output mult_req, flush, mem_to_reg, op_a, op_b,
        input  stall, result, result_valid, wb_sel
    );

    modport slave (
        input  mult_req, flush, mem_to_reg, op_a, op_b,
        output stall, result, result_valid, wb_sel
    );
endinterface

// File: rtl/mult_seq_ctrl_shift_add_dp.sv
// Shift-add multiply datapath: load latches the operands, each step adds the
// shifted multiplicand when the current multiplier bit is set.
module shift_add_dp #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] acc_next
);
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle MUL sequencer: stalls the pipeline for a fixed-latency shift-add
// multiply and steers the writeback mux to the product for one cycle.
//
//  state | meaning
//  IDLE  | no multiply in flight; a MUL in EX (not flushed) loads operands
//  RUN   | one shift-add step per cycle, DATA_W steps, pipeline stalled
//  DONE  | product presented for one cycle, stall released
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            arst,
    mult_seq_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] acc_next;
    logic              start;
    logic              running;
    logic              last_step;

    assign start     = (state == ST_IDLE) && bus.mult_req && !bus.flush;
    assign running   = (state == ST_RUN);
    assign last_step = (cnt == CNT_W'(DATA_W - 1));

    shift_add_dp #(.DATA_W(DATA_W)) u_dp (
        .clk      (clk),
        .arst     (arst),
        .load     (start),
        .step     (running),
        .op_a     (bus.op_a),
        .op_b     (bus.op_b),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    // A flush abandons the product; result keeps the previous value.
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_step) begin
                            result_q <= acc_next;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.stall        = start || running;
    assign bus.result       = result_q;
    assign bus.result_valid = (state == ST_DONE);
    assign bus.wb_sel       = wb_sel_for(state == ST_DONE, bus.mem_to_reg);
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: the driver pushes the arithmetic product
// of each issued MUL, an independent monitor pops and compares on result_valid.
module tb_mult_seq_ctrl;
    localparam int DATA_W = 32;
    localparam int LAT    = DATA_W + 2;

    logic clk;
    logic arst;
    int   checks;
    int   errors;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_result;

    mult_seq_ctrl_if #(.DATA_W(DATA_W)) bus ();

    mult_seq_ctrl #(.DATA_W(DATA_W)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] full;
        full = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return full[DATA_W-1:0];
    endfunction

    // Monitor: every cycle out of reset, check wb_sel and the result register.
    initial begin
        last_result = '0;
        forever begin
            @(negedge clk);
            if (arst) begin
                last_result = '0;
            end else begin
                if (bus.result_valid) begin
                    chk("wb_sel_done", bus.wb_sel, 2'b10);
                    chk("stall_done", bus.stall, 1'b0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", bus.result_valid, 1'b0);
                    end else begin
                        last_result = exp_q.pop_front();
                        chk("product", bus.result, last_result);
                    end
                end else begin
                    chk("wb_sel_nomul", bus.wb_sel, {1'b0, bus.mem_to_reg});
                    chk("result_hold", bus.result, last_result);
                end
            end
        end
    end

    // Issue one MUL at posedge+1; returns at posedge+1 after its DONE cycle with mult_req still 1.
    task automatic do_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        int cyc;
        int stalls;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.mult_req = 1'b1;
        exp_q.push_back(model_mul(a, b));
        cyc    = 0;
        stalls = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (bus.result_valid)
                break;
            if (bus.stall)
                stalls++;
            if (cyc == 4 * LAT) begin
                chk("timeout_valid", 1'b0, 1'b1);
                break;
            end
            // Operands are latched; scrambling them during RUN must not matter.
            if (cyc == 3) begin
                bus.op_a = $urandom;
                bus.op_b = $urandom;
            end
        end
        chk("latency", cyc, LAT);
        chk("stall_cycles", stalls, LAT - 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        bus.mult_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.mem_to_reg = $urandom_range(0, 1);
            @(negedge clk);
            chk("idle_stall", bus.stall, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        checks         = 0;
        errors         = 0;
        arst           = 1'b1;
        bus.mult_req   = 1'b0;
        bus.flush      = 1'b0;
        bus.mem_to_reg = 1'b1;
        bus.op_a       = '0;
        bus.op_b       = '0;

        repeat (2) @(negedge clk);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_result", bus.result, '0);
        chk("rst_valid", bus.result_valid, 1'b0);
        chk("rst_wb_sel", bus.wb_sel, 2'b01);
        @(posedge clk);
        #1 arst = 1'b0;
        bus.mem_to_reg = 1'b0;

        // Directed products including the all-ones and signed cases.
        do_mul(32'd7, 32'd6);
        idle_cycles(2);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle_cycles(1);
        do_mul(32'hFFFF_FFFD, 32'd5);
        idle_cycles(3);

        // Flush on the 10th RUN cycle: no pulse, result unchanged.
        bus.op_a     = 32'd1234;
        bus.op_b     = 32'd99;
        bus.mult_req = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        chk("stall_run_flush", bus.stall, 1'b1);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.mult_req = 1'b0;
        @(negedge clk);
        chk("stall_after_flush", bus.stall, 1'b0);
        chk("valid_after_flush", bus.result_valid, 1'b0);
        @(posedge clk);
        #1;
        idle_cycles(40);

        // Flush in IDLE suppresses the start.
        bus.mult_req = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        chk("stall_idle_flush", bus.stall, 1'b0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.mult_req = 1'b0;
        idle_cycles(3);

        // Back-to-back MULs, each with the full fixed latency.
        do_mul(32'd12, 32'd12);
        do_mul(32'd3, 32'd0);
        idle_cycles(2);

        // Asynchronous reset in the middle of RUN.
        bus.op_a     = 32'd55;
        bus.op_b     = 32'd66;
        bus.mult_req = 1'b1;
        repeat (6) @(posedge clk);
        #2 arst = 1'b1;
        bus.mult_req = 1'b0;
        #1;
        chk("arst_stall", bus.stall, 1'b0);
        chk("arst_result", bus.result, '0);
        chk("arst_valid", bus.result_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        do_mul(32'd55, 32'd66);
        idle_cycles(1);

        // Randomized operands, random gaps and mem_to_reg activity.
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            b = $urandom;
            if (n % 7 == 0)
                b = $urandom_range(0, 3);
            bus.mem_to_reg = $urandom_range(0, 1);
            do_mul(a, b);
            if ($urandom_range(0, 2) != 0)
                idle_cycles($urandom_range(1, 4));
        end
        idle_cycles(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
